// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock; result valid on a one-cycle done pulse.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d, bout;
  logic [WIDTH-1:0] res_nxt;

  fs_cell u_cell (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (bin),
    .d   (d),
    .bout(bout)
  );

  // Result fills from the top so the last bit lands in the MSB.
  assign res_nxt = {d, res[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic am, bm;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am     <= 1'b0;
      bm     <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            am    <= a[WIDTH-1];
            bm    <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          bin <= bout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_nxt;
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (am != bm) && (d != am);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized and directed checks of serial_sub against an arithmetic reference model.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk, rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] prev_diff;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_);
    checks++;
    if (obs !== exp_) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int x, y, r, sx, sy, sr;
    x  = int'(ta);
    y  = int'(tb_);
    r  = x - y;
    ed = W'(r);
    eb = (x < y);
    sx = x >= (1 << (W - 1)) ? x - (1 << W) : x;
    sy = y >= (1 << (W - 1)) ? y - (1 << W) : y;
    sr = sx - sy;
    eo = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_);
    logic [W-1:0] ed;
    logic eb, eo;
    model(ta, tb_, ed, eb, eo);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    prev_diff = ed;
  endtask

  // Called just after a negedge with the DUT in IDLE or DONE; returns after done has dropped.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_);
    int  n;
    bit  seen;
    start = 1'b1; a = ta; b = tb_;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    n = 0; seen = 0;
    while (!seen && n <= 3 * W) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_hold"}, 32'(diff), 32'(prev_diff));
        n++;
      end
    end
    chk({tag, "_lat"}, n, W);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    chk_result(tag, ta, tb_);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 0);
    chk({tag, "_stable"}, 32'(diff), 32'(prev_diff));
  endtask

  initial begin
    int cnt, gap;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    prev_diff = '0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op("d0503", 8'h05, 8'h03);
    run_op("d0305", 8'h03, 8'h05);
    run_op("d0001", 8'h00, 8'h01);
    run_op("d8001", 8'h80, 8'h01);
    run_op("d7fff", 8'h7F, 8'hFF);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 0) ra = '0;
      if (i % 5 == 0) rb = '1;
      run_op("rnd", ra, rb);
    end

    // start during SHIFT must be ignored
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; a = 8'hAA; b = W'($urandom);
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("ign_dones", cnt, 1);
    chk("ign_busy", 32'(busy), 0);
    chk_result("ign", 8'h10, 8'h01);

    // asynchronous reset mid-SHIFT
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h21;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_diff", 32'(diff), 0);
    chk("arst_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("arst_ovf", 32'(ovf), 0);
`endif
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    prev_diff = '0;
    run_op("post_rst", 8'h09, 8'h04);

    // back-to-back: start held through DONE
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    @(posedge clk); #1;
    gap = 0;
    while (!done && gap <= 3 * W) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_first", 32'(done), 1);
    chk_result("b2b1", 8'h5A, 8'h3C);
    a = 8'h11; b = 8'h22;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start = 1'b0;
    end while (!done && gap <= 3 * W);
    chk("b2b_gap", gap, W + 1);
    chk_result("b2b2", 8'h11, 8'h22);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one subtraction.
REQ-005 SHALL have port: a  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while bits are being processed.
REQ-008 SHALL have port: done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port: borrow  output  1  final borrow; high when a < b unsigned.
REQ-011 SHALL have port (SERIAL_SUB_OVF_EN only): ovf  output  1  signed two's-complement overflow.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only in IDLE or DONE: latch a and b into shift registers, clear the borrow flop to 0, clear the bit counter, and go to SHIFT.
REQ-014 SHALL ignore start while in SHIFT, with no effect on operands, counter or outputs.
REQ-015 SHALL in SHIFT each cycle process the LSBs: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin); shift d into the result MSB, shift both operand registers right, register bout.
REQ-016 SHALL leave SHIFT after exactly WIDTH SHIFT cycles, entering DONE.
REQ-017 SHALL hold done high for exactly the one DONE cycle; done is low in all other states.
REQ-018 SHALL assert busy exactly while in SHIFT.
REQ-019 SHALL produce a latency of WIDTH+1 rising edges from the edge that accepts start to the edge that returns done low, with done high in cycle WIDTH after acceptance.
REQ-020 SHALL leave DONE for IDLE unless start is high, in which case it accepts start (back-to-back, no idle cycle).
REQ-021 SHALL hold diff, borrow and ovf stable from DONE until the next accepted start completes; they update only on entry to DONE.
REQ-022 SHALL wrap modulo 2^WIDTH: 0 - 1 yields all ones with borrow=1.

Reset
REQ-023 SHALL on rst high, immediately and regardless of clk, force state IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, counter=0, internal borrow=0.
REQ-024 SHALL abandon any in-progress operation on reset, with no done pulse, and accept start on the first rising edge after rst falls.

Configuration
REQ-025 SHALL use macro SERIAL_SUB_OVF_EN: when defined, latch the operand MSBs at start and, on entry to DONE, set ovf = (a_msb != b_msb) && (diff_msb != a_msb).
REQ-026 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port or MSB latches, with all other behaviour unchanged.

Structure
REQ-027 SHALL place the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH constant in shared package serial_sub_pkg.
REQ-028 SHALL instantiate one combinational sub-module fs_cell (inputs x, y, bin; outputs d, bout) for the per-bit full-subtractor equation of REQ-015.
REQ-029 SHALL size the counter as clog2(WIDTH+1) bits.

Verification
REQ-030 SHALL cover: WIDTH=8, a=0x05, b=0x03, start 1 cycle -> done in cycle 8 after acceptance, diff=0x02, borrow=0, ovf=0.
REQ-031 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-032 SHALL cover, with SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
REQ-033 SHALL cover: start pulsed with a=0x10, b=0x01, then start again in SHIFT cycle 3 with a=0xAA -> ignored, diff=0x0F, single done pulse.
REQ-034 SHALL cover: rst asserted mid-SHIFT (cycle 4), asynchronously between edges -> outputs zero immediately, no done, next start a=0x09, b=0x04 -> diff=0x05.
REQ-035 SHALL cover: start held high through DONE -> new operands accepted in DONE cycle, second done exactly WIDTH+1 cycles after the first.
